// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Decode/operand-fetch stage. Holds the architectural
//                register file, services the writeback write port, reads two
//                source operands with same-cycle writeback bypass, stalls on
//                RAW/WAW hazards through a per-register busy scoreboard and
//                hands operands to execute through a valid/ready register.
//
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                id_*                   - decoded instruction in, id_ready out
//                ex_*                   - operand pipeline register to execute
//                wb_en/wb_addr/wb_data  - writeback write port
//
//  Options     : R0_ZERO_EN - register 0 is hardwired to zero (reads 0 on
//                every path, writes dropped, never marked busy).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    // decode side
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic [PC_W-1:0]   id_pc1,
    // execute side
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_rd_we,
    output logic [PC_W-1:0]   ex_pc1,
    // writeback port
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [ADDR_W-1:0] r_ex_rd;
    logic              r_ex_rd_we;
    logic [PC_W-1:0]   r_ex_pc1;

    logic              w_rs1_is_r0;
    logic              w_rs2_is_r0;
    logic              w_wb_write;   // writeback actually updates the file
    logic              w_rd_set;     // issue marks id_rd busy
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_wb_hit1;
    logic              w_wb_hit2;
    logic              w_wb_hitd;
    logic              w_src1_hazard;
    logic              w_src2_hazard;
    logic              w_waw_hazard;
    logic              w_issue;
    logic [NREG-1:0]   w_busy_next;

`ifdef R0_ZERO_EN
    assign w_rs1_is_r0 = (id_rs1 == '0);
    assign w_rs2_is_r0 = (id_rs2 == '0);
    assign w_wb_write  = wb_en && (wb_addr != '0);
    assign w_rd_set    = id_rd_we && (id_rd != '0);
`else
    assign w_rs1_is_r0 = 1'b0;
    assign w_rs2_is_r0 = 1'b0;
    assign w_wb_write  = wb_en;
    assign w_rd_set    = id_rd_we;
`endif

    assign w_wb_hit1 = wb_en && (wb_addr == id_rs1);
    assign w_wb_hit2 = wb_en && (wb_addr == id_rs2);
    assign w_wb_hitd = wb_en && (wb_addr == id_rd);

    // Zero override sits outside the bypass so a write to r0 can never leak
    // through the forwarding path.
    assign w_rd1 = w_rs1_is_r0 ? '0 : (w_wb_hit1 ? wb_data : r_regs[id_rs1]);
    assign w_rd2 = w_rs2_is_r0 ? '0 : (w_wb_hit2 ? wb_data : r_regs[id_rs2]);

    // A register being written back this cycle is no longer pending: the
    // bypass supplies its value, so it does not stall.
    assign w_src1_hazard = r_busy[id_rs1] && !w_wb_hit1;
    assign w_src2_hazard = r_busy[id_rs2] && !w_wb_hit2;
    assign w_waw_hazard  = w_rd_set && r_busy[id_rd] && !w_wb_hitd;

    assign id_ready = !w_src1_hazard && !w_src2_hazard && !w_waw_hazard &&
                      (!r_ex_valid || ex_ready);
    assign w_issue  = id_valid && id_ready;

    // Clear first, then set: an issue claiming the register that is retiring
    // in the same cycle leaves it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (wb_en) begin
            w_busy_next[wb_addr] = 1'b0;
        end
        if (w_issue && w_rd_set) begin
            w_busy_next[id_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy     <= '0;
            r_ex_valid <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_rd    <= '0;
            r_ex_rd_we <= 1'b0;
            r_ex_pc1   <= '0;
        end else begin
            if (w_wb_write) begin
                r_regs[wb_addr] <= wb_data;
            end
            r_busy <= w_busy_next;

            if (w_issue) begin
                r_ex_valid <= 1'b1;
                r_ex_a     <= w_rd1;
                r_ex_b     <= w_rd2;
                r_ex_rd    <= id_rd;
                r_ex_rd_we <= id_rd_we;
                r_ex_pc1   <= id_pc1;
            end else if (ex_ready) begin
                // Drain: data outputs keep their last value.
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_a     = r_ex_a;
    assign ex_b     = r_ex_b;
    assign ex_rd    = r_ex_rd;
    assign ex_rd_we = r_ex_rd_we;
    assign ex_pc1   = r_ex_pc1;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Directed, table-driven bench for operand_fetch. Each record
//                gives the inputs for one cycle, the expected id_ready during
//                that cycle and the expected ex_* outputs after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

`ifdef R0_ZERO_EN
    localparam bit c_r0 = 1'b1;
`else
    localparam bit c_r0 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic [2:0]  id_rd;
    logic        id_rd_we;
    logic [7:0]  id_pc1;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [2:0]  ex_rd;
    logic        ex_rd_we;
    logic [7:0]  ex_pc1;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_fetch #(
        .DATA_W(16), .NREG(8), .ADDR_W(3), .PC_W(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_rs1  (id_rs1),
        .id_rs2  (id_rs2),
        .id_rd   (id_rd),
        .id_rd_we(id_rd_we),
        .id_pc1  (id_pc1),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_a    (ex_a),
        .ex_b    (ex_b),
        .ex_rd   (ex_rd),
        .ex_rd_we(ex_rd_we),
        .ex_pc1  (ex_pc1),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    typedef struct {
        logic        rst;
        logic        wbe;
        logic [2:0]  wba;
        logic [15:0] wbd;
        logic        idv;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [2:0]  rd;
        logic        we;
        logic [7:0]  pc;
        logic        exr;
        logic        chk_rdy;
        logic        e_rdy;
        logic        e_val;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [2:0]  e_rd;
        logic        e_we;
        logic [7:0]  e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic wbe, input logic [2:0] wba, input logic [15:0] wbd,
        input logic idv, input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
        input logic we, input logic [7:0] pc, input logic exr, input logic chk_rdy,
        input logic e_rdy, input logic e_val, input logic [15:0] e_a, input logic [15:0] e_b,
        input logic [2:0] e_rd, input logic e_we, input logic [7:0] e_pc);
        vec_t v;
        v.rst = rst; v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.idv = idv;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.pc = pc; v.exr = exr;
        v.chk_rdy = chk_rdy; v.e_rdy = e_rdy; v.e_val = e_val; v.e_a = e_a;
        v.e_b = e_b; v.e_rd = e_rd; v.e_we = e_we; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset    = v.rst;
        wb_en    = v.wbe;
        wb_addr  = v.wba;
        wb_data  = v.wbd;
        id_valid = v.idv;
        id_rs1   = v.rs1;
        id_rs2   = v.rs2;
        id_rd    = v.rd;
        id_rd_we = v.we;
        id_pc1   = v.pc;
        ex_ready = v.exr;
        #1;
        if (v.chk_rdy) check({tag, " id_ready"}, 32'(id_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        check({tag, " ex_valid"}, 32'(ex_valid), 32'(v.e_val));
        check({tag, " ex_a"},     32'(ex_a),     32'(v.e_a));
        check({tag, " ex_b"},     32'(ex_b),     32'(v.e_b));
        check({tag, " ex_rd"},    32'(ex_rd),    32'(v.e_rd));
        check({tag, " ex_rd_we"}, 32'(ex_rd_we), 32'(v.e_we));
        check({tag, " ex_pc1"},   32'(ex_pc1),   32'(v.e_pc));
    endtask

    initial begin
        logic [15:0] r0v;
        reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; id_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_we = 1'b0; id_pc1 = '0; ex_ready = 1'b1;

        // rst wbe wba wbd idv rs1 rs2 rd we pc exr chk rdy | val a b rd we pc
        tbl.push_back(mk(1,0,0,16'h0,   0,0,0,0,0,8'h00,1, 0,0, 0,16'h0,16'h0,0,0,8'h00));
        // reset then read
        tbl.push_back(mk(0,0,0,16'h0,   1,3,5,1,0,8'h10,1, 1,1, 1,16'h0,16'h0,1,0,8'h10));
        // write r2, drain
        tbl.push_back(mk(0,1,2,16'h1234,0,0,0,0,0,8'h00,1, 1,1, 0,16'h0,16'h0,1,0,8'h10));
        tbl.push_back(mk(0,0,0,16'h0,   1,2,0,3,0,8'h11,1, 1,1, 1,16'h1234,16'h0,3,0,8'h11));
        // same-cycle bypass on rs2
        tbl.push_back(mk(0,1,4,16'hBEEF,1,2,4,5,0,8'h12,1, 1,1, 1,16'h1234,16'hBEEF,5,0,8'h12));
        // RAW: rd=6 busy, then stalled reader, released by writeback
        tbl.push_back(mk(0,0,0,16'h0,   1,4,4,6,1,8'h13,1, 1,1, 1,16'hBEEF,16'hBEEF,6,1,8'h13));
        tbl.push_back(mk(0,0,0,16'h0,   1,6,0,1,0,8'h14,1, 1,0, 0,16'hBEEF,16'hBEEF,6,1,8'h13));
        tbl.push_back(mk(0,0,0,16'h0,   1,6,0,1,0,8'h14,1, 1,0, 0,16'hBEEF,16'hBEEF,6,1,8'h13));
        tbl.push_back(mk(0,1,6,16'h00AA,1,6,0,1,0,8'h14,1, 1,1, 1,16'h00AA,16'h0,1,0,8'h14));
        // WAW on r7, released by writeback; re-set in same cycle wins
        tbl.push_back(mk(0,0,0,16'h0,   1,1,2,7,1,8'h15,1, 1,1, 1,16'h0,16'h1234,7,1,8'h15));
        tbl.push_back(mk(0,0,0,16'h0,   1,0,0,7,1,8'h16,1, 1,0, 0,16'h0,16'h1234,7,1,8'h15));
        tbl.push_back(mk(0,1,7,16'h5555,1,0,0,7,1,8'h16,1, 1,1, 1,16'h0,16'h0,7,1,8'h16));
        tbl.push_back(mk(0,0,0,16'h0,   1,7,3,2,0,8'h17,1, 1,0, 0,16'h0,16'h0,7,1,8'h16));
        tbl.push_back(mk(0,1,7,16'h7777,1,7,7,2,0,8'h17,1, 1,1, 1,16'h7777,16'h7777,2,0,8'h17));
        // RAW on rs2
        tbl.push_back(mk(0,0,0,16'h0,   1,1,1,5,1,8'h18,1, 1,1, 1,16'h0,16'h0,5,1,8'h18));
        tbl.push_back(mk(0,0,0,16'h0,   1,0,5,1,0,8'h19,1, 1,0, 0,16'h0,16'h0,5,1,8'h18));
        tbl.push_back(mk(0,1,5,16'h0F0F,1,0,5,1,0,8'h19,1, 1,1, 1,16'h0,16'h0F0F,1,0,8'h19));
        // backpressure: drain, issue A, hold 3 cycles, then B on release
        tbl.push_back(mk(0,0,0,16'h0,   0,0,0,0,0,8'h00,1, 1,1, 0,16'h0,16'h0F0F,1,0,8'h19));
        tbl.push_back(mk(0,0,0,16'h0,   1,2,4,3,0,8'h20,0, 1,1, 1,16'h1234,16'hBEEF,3,0,8'h20));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,0,0,16'h0,1,7,6,5,0,8'h21,0, 1,0, 1,16'h1234,16'hBEEF,3,0,8'h20));
        tbl.push_back(mk(0,0,0,16'h0,   1,7,6,5,0,8'h21,1, 1,1, 1,16'h7777,16'h00AA,5,0,8'h21));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Reset mid-flight overrides a same-cycle issue and writeback.
        apply(mk(1,1,2,16'h9999,1,7,0,4,1,8'h33,1, 0,0, 0,16'h0,16'h0,0,0,8'h00), "rst_mid");
        apply(mk(0,0,0,16'h0,   1,4,2,4,0,8'h40,1, 1,1, 1,16'h0,16'h0,4,0,8'h40), "post_rst0");
        apply(mk(0,0,0,16'h0,   1,4,2,1,0,8'h41,1, 1,1, 1,16'h0,16'h0,1,0,8'h41), "post_rst1");

        // Register 0 behaviour (hardwired zero or ordinary register).
        r0v = c_r0 ? 16'h0000 : 16'hFFFF;
        apply(mk(0,1,0,16'hFFFF,0,0,0,0,0,8'h00,1, 1,1, 0,16'h0,16'h0,1,0,8'h41), "r0_wr");
        apply(mk(0,0,0,16'h0,   1,0,0,0,1,8'h30,1, 1,1, 1,r0v,r0v,0,1,8'h30), "r0_rd");
        if (c_r0)
            apply(mk(0,0,0,16'h0,1,0,1,0,1,8'h31,1, 1,1, 1,16'h0,16'h0,0,1,8'h31), "r0_nostall");
        else
            apply(mk(0,0,0,16'h0,1,0,1,0,1,8'h31,1, 1,0, 0,r0v,r0v,0,1,8'h30), "r0_stall");
        apply(mk(0,1,0,16'h1111,1,0,1,0,1,8'h31,1, 1,1, 1,(c_r0 ? 16'h0 : 16'h1111),16'h0,0,1,8'h31),
              "r0_bypass");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
